// File: rtl/capture_relay.sv
// capture_relay
//   Capture-and-forward buffer between the ADC reader and the serial writer.
//   An arm pulse starts a run of N samples (depth_cfg clamped to 1..DEPTH).
//   The samples are stored and then streamed oldest-first over tx_valid/tx_ready.
//   The block then returns to idle. An abort returns it to idle from any state.
//   adc_valid strobes that arrive while streaming are dropped and counted in overrun.
//
//   Optional feature: define CAPTURE_RELAY_TRIGGER_EN to build the WAIT_TRIG
//   state. In that state, capture starts at the first sample >= trig_level.
//   In the default build trig_level is unused and must be tied off.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   arm, abort      run start (honoured only in idle), synchronous abort
//   depth_cfg       samples per run, sampled on the arm cycle
//   adc_valid/data  ADC sample strobe and data
//   trig_level      trigger threshold (trigger build only)
//   tx_valid/ready  handshake to the writer, tx_data is the word on offer
//   busy, done      not idle / one-cycle pulse after the final word is accepted
//   fill            samples captured in the current (or last) run
//   overrun         saturating count of dropped strobes, cleared only by rst
module capture_relay #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [CNT_W-1:0]  depth_cfg,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  fill,
  output logic [7:0]        overrun
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
`ifdef CAPTURE_RELAY_TRIGGER_EN
    WAIT_TRIG = 2'd1,
`endif
    CAPTURE   = 2'd2,
    SEND      = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  n_len;      // run length latched on arm
  logic [CNT_W-1:0]  rd_ptr;     // index of the word currently on tx_data
  logic [CNT_W-1:0]  n_clamped;
  logic [CNT_W-1:0]  next_rd;
  logic [DATA_W-1:0] first_word;
  logic              wr_en;
  logic [DATA_W-1:0] mem [DEPTH];

`ifndef CAPTURE_RELAY_TRIGGER_EN
  logic unused_trig;
  assign unused_trig = ^trig_level;
`endif

  // Samples are written in order starting at index 0, so fill doubles as the
  // write pointer.
  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    wr_en = 1'b0;
    if (!abort && adc_valid) begin
      if (state == CAPTURE) wr_en = 1'b1;
`ifdef CAPTURE_RELAY_TRIGGER_EN
      if (state == WAIT_TRIG && adc_data >= trig_level) wr_en = 1'b1;
`endif
    end
  end

  always_comb begin
    if (depth_cfg == '0)          n_clamped = ONE_C;
    else if (depth_cfg > DEPTH_C) n_clamped = DEPTH_C;
    else                          n_clamped = depth_cfg;
  end

  assign next_rd = rd_ptr + ONE_C;
  // On entry to SEND, word 0 may be the sample being written in this same cycle.
  // That happens only when N = 1.
  assign first_word = (fill == '0) ? adc_data : mem[0];

  // NOTE: the sample buffer has no reset. Its contents are only read after they
  // have been written in the current run, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[fill[AW-1:0]] <= adc_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      n_len    <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overrun  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              n_len  <= n_clamped;
              fill   <= '0;
              rd_ptr <= '0;
              busy   <= 1'b1;
`ifdef CAPTURE_RELAY_TRIGGER_EN
              state  <= WAIT_TRIG;
`else
              state  <= CAPTURE;
`endif
            end
          end
`ifdef CAPTURE_RELAY_TRIGGER_EN
          WAIT_TRIG: begin
            if (wr_en) begin
              fill <= ONE_C;
              if (n_len == ONE_C) begin
                state    <= SEND;
                tx_valid <= 1'b1;
                tx_data  <= adc_data;
              end else begin
                state <= CAPTURE;
              end
            end
          end
`endif
          CAPTURE: begin
            if (adc_valid) begin
              fill <= fill + ONE_C;
              if (fill + ONE_C == n_len) begin
                state    <= SEND;
                tx_valid <= 1'b1;
                tx_data  <= first_word;
              end
            end
          end
          SEND: begin
            if (adc_valid && overrun != 8'hFF) overrun <= overrun + 8'd1;
            if (tx_ready) begin
              if (next_rd == n_len) begin
                state    <= IDLE;
                tx_valid <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                rd_ptr  <= next_rd;
                tx_data <= mem[next_rd[AW-1:0]];
              end
            end
          end
          default: begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
